// File: rtl/and_share_arbiter.sv
// and_share_arbiter
// Round-robin arbiter and three-state sequencer that time-shares a single
// registered AND-evaluation unit between N_REQ requesters. A granted
// requester's operands are latched and evaluated in a dedicated cycle. The
// result is then returned with the owning requester's index.

module and_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   a_in,
    input  logic [N_REQ*W-1:0]   b_in,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_all_ones,
    output logic [15:0]          ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   search_idx;
    logic              winner_found;
    logic              any_req;
    logic              grant_fire;

    logic [W-1:0]      sel_a;
    logic [W-1:0]      sel_b;
    logic [N_REQ-1:0]  winner_onehot;

    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic [W-1:0]      res_q;
    logic [ID_W-1:0]   id_q;

    assign any_req    = |req;
    assign grant_fire = (state == IDLE) && any_req;

    // Busy is a pure decode of the registered state, never of the inputs.
    assign busy = (state != IDLE);

    // Round-robin search: first set request above ptr, wrapping, ptr itself last.
    always_comb begin
        winner       = ptr;
        winner_found = 1'b0;
        search_idx   = ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            search_idx = ptr + ID_W'(k);
            if (!winner_found && req[search_idx]) begin
                winner_found = 1'b1;
                winner       = search_idx;
            end
        end
    end

    // Steer the winner's operand slices and build its one-hot grant vector.
    always_comb begin
        sel_a         = '0;
        sel_b         = '0;
        winner_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a            = a_in[i*W +: W];
                sel_b            = b_in[i*W +: W];
                winner_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state logic: IDLE waits for any request, EXEC and DONE last one cycle each.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = any_req ? EXEC : IDLE;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, operand capture and pointer update on the grant edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr  <= ID_W'(N_REQ - 1);
            gnt  <= '0;
            op_a <= '0;
            op_b <= '0;
            id_q <= '0;
        end else begin
            gnt <= '0;
            if (grant_fire) begin
                ptr  <= winner;
                gnt  <= winner_onehot;
                op_a <= sel_a;
                op_b <= sel_b;
                id_q <= winner;
            end
        end
    end

    // Shared AND unit: evaluates the latched operands during EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (state == EXEC) begin
            res_q <= op_a & op_b;
        end
    end

    // Response publication in DONE; the data fields hold until the next DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_all_ones <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == DONE) begin
                rsp_valid    <= 1'b1;
                rsp_id       <= id_q;
                rsp_data     <= res_q;
                rsp_all_ones <= &res_q;
            end
        end
    end

    // Completed-operation counter, saturating at its maximum value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if ((state == DONE) && (ops_done != 16'hFFFF)) begin
            ops_done <= ops_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_and_share_arbiter.sv
// tb_and_share_arbiter
// Cycle-by-cycle directed vectors for and_share_arbiter (N_REQ=4, W=8),
// followed by hand-written sequences for resets landing mid-operation.

module tb_and_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic        busy;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_all_ones;
    logic [15:0] ops_done;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  gnt;
        logic        busy;
        logic        rv;
        logic [1:0]  id;
        logic [7:0]  data;
        logic        ao;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    localparam logic [31:0] A_C  = 32'hAA33F00F;
    localparam logic [31:0] B_C  = 32'hFA3F3CFF;
    localparam logic [31:0] A_S  = 32'h00F00000;
    localparam logic [31:0] B_S  = 32'h003C0000;
    localparam logic [31:0] A_FF = 32'h0000FF00;
    localparam logic [31:0] B_FE = 32'h0000FE00;

    and_share_arbiter #(.N_REQ(4), .W(8), .ID_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .a_in         (a_in),
        .b_in         (b_in),
        .gnt          (gnt),
        .busy         (busy),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_all_ones (rsp_all_ones),
        .ops_done     (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [3:0] q, logic [31:0] a, logic [31:0] b,
                                logic [3:0] g, logic bs, logic rv, logic [1:0] id,
                                logic [7:0] d, logic ao, logic [15:0] c);
        vec_t v;
        v.rst_n = r;  v.req = q;   v.a = a;    v.b = b;
        v.gnt = g;    v.busy = bs; v.rv = rv;  v.id = id;
        v.data = d;   v.ao = ao;   v.cnt = c;
        return v;
    endfunction

    // Drive inputs away from the active edge, then step past the edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n = v.rst_n;
        req   = v.req;
        a_in  = v.a;
        b_in  = v.b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        vec_count++;
        if (gnt !== v.gnt || busy !== v.busy || rsp_valid !== v.rv || rsp_id !== v.id ||
            rsp_data !== v.data || rsp_all_ones !== v.ao || ops_done !== v.cnt) begin
            miss_count++;
            $display("[TB] FAIL %s: got gnt=%b busy=%b rv=%b id=%0d data=%h ao=%b cnt=%0d, expected gnt=%b busy=%b rv=%b id=%0d data=%h ao=%b cnt=%0d",
                     name, gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_all_ones, ops_done,
                     v.gnt, v.busy, v.rv, v.id, v.data, v.ao, v.cnt);
        end
    endtask

    initial begin
        vec_t v;
        int   wait_cycles;
        bit   seen;

        rst_n = 1'b0;
        req   = 4'b0000;
        a_in  = '0;
        b_in  = '0;

        //          rst req    a     b     gnt  bsy rv id data   ao cnt
        // reset held with all requests asserted
        vq.push_back(mk(0, 4'hF, A_C, B_C, 4'h0, 0, 0, 0, 8'h00, 0, 0));
        vq.push_back(mk(0, 4'hF, A_C, B_C, 4'h0, 0, 0, 0, 8'h00, 0, 0));
        vq.push_back(mk(1, 4'h0, A_C, B_C, 4'h0, 0, 0, 0, 8'h00, 0, 0));
        // full contention: grants 0,1,2,3,0 every third cycle
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h1, 1, 0, 0, 8'h00, 0, 0));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h0, 1, 0, 0, 8'h00, 0, 0));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h0, 0, 1, 0, 8'h0F, 0, 1));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h2, 1, 0, 0, 8'h0F, 0, 1));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h0, 1, 0, 0, 8'h0F, 0, 1));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h0, 0, 1, 1, 8'h30, 0, 2));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h4, 1, 0, 1, 8'h30, 0, 2));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h0, 1, 0, 1, 8'h30, 0, 2));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h0, 0, 1, 2, 8'h33, 0, 3));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h8, 1, 0, 2, 8'h33, 0, 3));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h0, 1, 0, 2, 8'h33, 0, 3));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h0, 0, 1, 3, 8'hAA, 0, 4));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h1, 1, 0, 3, 8'hAA, 0, 4));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h0, 1, 0, 3, 8'hAA, 0, 4));
        vq.push_back(mk(1, 4'hF, A_C, B_C, 4'h0, 0, 1, 0, 8'h0F, 0, 5));
        // lone request from 3, then 0110: wrap to 1, then 2
        vq.push_back(mk(1, 4'h8, A_C, B_C, 4'h8, 1, 0, 0, 8'h0F, 0, 5));
        vq.push_back(mk(1, 4'h6, A_C, B_C, 4'h0, 1, 0, 0, 8'h0F, 0, 5));
        vq.push_back(mk(1, 4'h6, A_C, B_C, 4'h0, 0, 1, 3, 8'hAA, 0, 6));
        vq.push_back(mk(1, 4'h6, A_C, B_C, 4'h2, 1, 0, 3, 8'hAA, 0, 6));
        vq.push_back(mk(1, 4'h6, A_C, B_C, 4'h0, 1, 0, 3, 8'hAA, 0, 6));
        vq.push_back(mk(1, 4'h6, A_C, B_C, 4'h0, 0, 1, 1, 8'h30, 0, 7));
        vq.push_back(mk(1, 4'h6, A_C, B_C, 4'h4, 1, 0, 1, 8'h30, 0, 7));
        vq.push_back(mk(1, 4'h0, A_C, B_C, 4'h0, 1, 0, 1, 8'h30, 0, 7));
        vq.push_back(mk(1, 4'h0, A_C, B_C, 4'h0, 0, 1, 2, 8'h33, 0, 8));
        vq.push_back(mk(1, 4'h0, A_C, B_C, 4'h0, 0, 0, 2, 8'h33, 0, 8));
        // single request from 2: F0 & 3C, operands cleared after grant
        vq.push_back(mk(1, 4'h4, A_S, B_S, 4'h4, 1, 0, 2, 8'h33, 0, 8));
        vq.push_back(mk(1, 4'h0, '0,  '0,  4'h0, 1, 0, 2, 8'h33, 0, 8));
        vq.push_back(mk(1, 4'h0, '0,  '0,  4'h0, 0, 1, 2, 8'h30, 0, 9));
        vq.push_back(mk(1, 4'h0, '0,  '0,  4'h0, 0, 0, 2, 8'h30, 0, 9));
        // all-ones operands on requester 1, then FF & FE
        vq.push_back(mk(1, 4'h2, A_FF, A_FF, 4'h2, 1, 0, 2, 8'h30, 0, 9));
        vq.push_back(mk(1, 4'h0, A_FF, B_FE, 4'h0, 1, 0, 2, 8'h30, 0, 9));
        vq.push_back(mk(1, 4'h0, A_FF, B_FE, 4'h0, 0, 1, 1, 8'hFF, 1, 10));
        vq.push_back(mk(1, 4'h2, A_FF, B_FE, 4'h2, 1, 0, 1, 8'hFF, 1, 10));
        vq.push_back(mk(1, 4'h0, A_FF, B_FE, 4'h0, 1, 0, 1, 8'hFF, 1, 10));
        vq.push_back(mk(1, 4'h0, A_FF, B_FE, 4'h0, 0, 1, 1, 8'hFE, 0, 11));
        vq.push_back(mk(1, 4'h0, A_FF, B_FE, 4'h0, 0, 0, 1, 8'hFE, 0, 11));

        foreach (vq[i]) begin
            applyStimulus(vq[i]);
            checkOutput(vq[i], $sformatf("vec%0d", i));
        end

        // Reset landing on the EXEC edge: operation aborted, counter cleared.
        v = mk(1, 4'h4, A_S, B_S, 4'h4, 1, 0, 1, 8'hFE, 0, 11);
        applyStimulus(v); checkOutput(v, "rst_exec_grant");
        v = mk(0, 4'h0, A_S, B_S, 4'h0, 0, 0, 0, 8'h00, 0, 0);
        applyStimulus(v); checkOutput(v, "rst_exec_reset");
        for (int i = 0; i < 3; i++) begin
            v = mk(1, 4'h0, A_S, B_S, 4'h0, 0, 0, 0, 8'h00, 0, 0);
            applyStimulus(v); checkOutput(v, $sformatf("rst_exec_quiet%0d", i));
        end
        // Requester 0 regains top priority after reset.
        v = mk(1, 4'hF, A_C, B_C, 4'h1, 1, 0, 0, 8'h00, 0, 0);
        applyStimulus(v); checkOutput(v, "rst_exec_regrant");

        // Bounded wait for the response of the post-reset grant.
        wait_cycles = 0;
        seen        = 1'b0;
        v = mk(1, 4'h0, A_C, B_C, 4'h0, 0, 0, 0, 8'h00, 0, 0);
        while (!seen && wait_cycles < 8) begin
            applyStimulus(v);
            wait_cycles++;
            seen = rsp_valid;
        end
        vec_count++;
        if (!seen || wait_cycles != 2 || rsp_id !== 2'd0 || rsp_data !== 8'h0F || ops_done !== 16'd1) begin
            miss_count++;
            $display("[TB] FAIL post_reset_rsp: got seen=%b after %0d cycles id=%0d data=%h cnt=%0d, expected seen=1 after 2 cycles id=0 data=0f cnt=1",
                     seen, wait_cycles, rsp_id, rsp_data, ops_done);
        end

        // Reset landing on the DONE edge: no response pulse escapes.
        v = mk(1, 4'h2, A_C, B_C, 4'h2, 1, 0, 0, 8'h0F, 0, 1);
        applyStimulus(v); checkOutput(v, "rst_done_grant");
        v = mk(1, 4'h0, A_C, B_C, 4'h0, 1, 0, 0, 8'h0F, 0, 1);
        applyStimulus(v); checkOutput(v, "rst_done_exec");
        v = mk(0, 4'h0, A_C, B_C, 4'h0, 0, 0, 0, 8'h00, 0, 0);
        applyStimulus(v); checkOutput(v, "rst_done_reset");
        v = mk(1, 4'h0, A_C, B_C, 4'h0, 0, 0, 0, 8'h00, 0, 0);
        applyStimulus(v); checkOutput(v, "rst_done_quiet");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/and_share_arbiter.md
# and_share_arbiter

Round-robin arbiter and sequencer that time-shares one registered AND-evaluation unit between up to N requesters. Each requester presents two operands and a request. The block grants one requester at a time, latches its operands and evaluates the bitwise AND in a dedicated cycle. It then returns the result tagged with the requester index. It sits between several request sources and the single shared AND datapath, and is the only path through which that datapath is driven.

## Interface
- `N_REQ`, default 4: number of requesters; power of two, 2..8.
- `W`, default 8: operand and result width in bits.
- `ID_W`, default 2: log2(N_REQ).
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req` input N_REQ: per-requester request level.
- `a_in` input N_REQ*W: operand A; requester i uses bits [i*W +: W].
- `b_in` input N_REQ*W: operand B; same packing as `a_in`.
- `gnt` output N_REQ: one-hot grant, high for exactly one cycle per accepted request.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `rsp_valid` output 1: one-cycle pulse marking a valid result.
- `rsp_id` output ID_W: index of the requester that owns the result.
- `rsp_data` output W: result, equal to a AND b.
- `rsp_all_ones` output 1: high when `rsp_data` is all ones, i.e. both operands were all ones.
- `ops_done` output 16: count of completed operations; saturates at 0xFFFF.

## Operation
- The FSM has three states:
  - IDLE → EXEC when any `req` bit is high; otherwise it stays in IDLE.
  - EXEC → DONE unconditionally.
  - DONE → IDLE unconditionally.
- Grant selection in IDLE:
  - The winner is the first set `req` bit searching upward from `ptr`+1, wrapping modulo N_REQ.
  - On the grant edge: `ptr` ← winner, `gnt` ← onehot(winner), winner's operands latched into `op_a`/`op_b`, `id_q` ← winner.
- EXEC: `res_q` ← `op_a` & `op_b`; `gnt` ← 0.
- DONE:
  - `rsp_valid` ← 1, `rsp_data` ← `res_q`, `rsp_id` ← `id_q`, `rsp_all_ones` ← (`res_q` == all ones).
  - `ops_done` ← `ops_done`+1 unless it is already 0xFFFF.
- `rsp_valid` clears on the next edge. `rsp_data`, `rsp_id` and `rsp_all_ones` hold their last values until the next DONE.
- `req` is ignored in EXEC and DONE. A `req` still high when the FSM returns to IDLE is treated as a new request.
- Requester protocol:
  - Hold `req` and operands stable until `gnt` is seen.
  - Drop `req` on the edge that ends the `gnt` cycle unless another operation is wanted.
  - Operands may change freely after the grant edge.
- `busy` is a decode of the registered state; it has no combinational path from inputs.

## Timing
- Reset (`rst_n` low at an edge):
  - State → IDLE.
  - `gnt`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_all_ones` → 0.
  - `ops_done` → 0.
  - `ptr` → N_REQ-1, so requester 0 has first priority.
  - `busy` → 0.
- Reset during EXEC or DONE aborts the in-flight operation: no `rsp_valid` is produced, the counter is cleared, and the FSM restarts from IDLE on the first edge with `rst_n` high.
- Latency, with `req` sampled at edge E0 in IDLE:
  - `gnt` is high during E0..E1.
  - `rsp_valid` is high during E2..E3.
- Throughput: at most one grant every 3 cycles. With continuous requests, the next grant occurs at E3, on the same edge that clears `rsp_valid`.
- Simultaneous requests: exactly one grant per grant edge; losers keep waiting.
- Fairness: a requester that holds `req` is granted within N_REQ grants.
- Pointer wrap: with `ptr` = N_REQ-1, the search starts at index 0.
- Counter at 0xFFFF: stays at 0xFFFF; `rsp_valid` is still produced.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with `req`=4'b1111 → `gnt`=0, `busy`=0, `rsp_valid`=0, `rsp_data`=0x00, `ops_done`=0 throughout.
- Single request: `req`=4'b0100, a2=0xF0, b2=0x3C → `gnt`=4'b0100 for one cycle; `rsp_valid` 2 cycles later with `rsp_id`=2, `rsp_data`=0x30, `rsp_all_ones`=0; `ops_done`=1.
- Full contention: `req`=4'b1111 held continuously → grants in order 0,1,2,3,0 at 3-cycle spacing; `rsp_id` sequence 0,1,2,3,0.
- Wrap and skip: after a grant to 3, present `req`=4'b0110 → grant to 1, then to 2; no grant to 0 or 3.
- All-ones operands: a1=b1=0xFF → `rsp_data`=0xFF, `rsp_all_ones`=1. Follow with a1=0xFF, b1=0xFE → `rsp_data`=0xFE, `rsp_all_ones`=0.
- Reset mid-operation: assert `rst_n`=0 for one cycle while in EXEC → no `rsp_valid` appears, `ops_done`=0, and the next request is served normally with requester 0 at top priority.
